// File: rtl/mdu_pkg.sv
// Shared types for the pipeline multiply/divide unit: operation encoding,
// FSM states and the elaboration-time legality check on R.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  function automatic bit mdu_r_legal(input int r, input int xlen);
    return ((r == 1) || (r == 2) || (r == 4)) && ((xlen % r) == 0);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Operates on magnitudes only; sign handling lives in the top level.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    // Multiply: conditionally add multiplicand, then shift {carry, hi, lo} right.
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    // Divide: the partial remainder is XLEN+1 bits once the next dividend bit enters.
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_fits  = (w_shift >= {1'b0, i_m});
    w_diff  = w_shift[XLEN-1:0] - i_m;
    if (i_is_div) begin
      o_hi = w_fits ? w_diff : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_fits};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pipeline_mdu.sv
// Iterative multiply/divide unit beside the execute-stage ALU: owns HI/LO,
// services MF*/MT* and stalls the pipeline while an operation iterates.
module pipeline_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int R    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            MDValidE,
  input  md_op_t          MDOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            AbortE,
  output logic            BusyE,
  output logic            StallMD,
  output logic [XLEN-1:0] MDOutE,
  output logic            DoneE
);

  localparam int ITERS = XLEN / R;
  localparam int CW    = $clog2(ITERS + 1);

  if (!mdu_r_legal(R, XLEN)) begin : g_bad_r
    $error("pipeline_mdu: R must be 1, 2 or 4 and divide XLEN");
  end

  mdu_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo;
  logic [XLEN-1:0] r_acc_hi, r_acc_lo, r_m;
  logic            r_is_div, r_neg_q, r_neg_r, r_div_zero, r_done;

  logic            w_is_mul, w_is_divop, w_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs;

  assign w_is_mul   = (MDOpE == MD_MULT) || (MDOpE == MD_MULTU);
  assign w_is_divop = (MDOpE == MD_DIV)  || (MDOpE == MD_DIVU);
  assign w_signed   = (MDOpE == MD_MULT) || (MDOpE == MD_DIV);
  assign w_a_neg    = w_signed & SrcAE[XLEN-1];
  assign w_b_neg    = w_signed & SrcBE[XLEN-1];
  assign w_a_abs    = w_a_neg ? -SrcAE : SrcAE;
  assign w_b_abs    = w_b_neg ? -SrcBE : SrcBE;

  logic [XLEN-1:0] w_hi_chain [R+1];
  logic [XLEN-1:0] w_lo_chain [R+1];

  assign w_hi_chain[0] = r_acc_hi;
  assign w_lo_chain[0] = r_acc_lo;

  for (genvar g = 0; g < R; g++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .i_is_div (r_is_div),
      .i_hi     (w_hi_chain[g]),
      .i_lo     (w_lo_chain[g]),
      .i_m      (r_m),
      .o_hi     (w_hi_chain[g+1]),
      .o_lo     (w_lo_chain[g+1])
    );
  end

  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_prod   = {r_acc_hi, r_acc_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  // Divide by zero leaves an all-ones magnitude quotient; force it so the sign fix cannot flip it.
  assign w_quo    = r_div_zero ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
  assign w_rem    = r_neg_r ? -r_acc_hi : r_acc_hi;
  assign w_res_hi = r_is_div ? w_rem : w_prod_s[2*XLEN-1:XLEN];
  assign w_res_lo = r_is_div ? w_quo : w_prod_s[XLEN-1:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: every register, datapath latches included, is reset; they are few and a clean start is cheap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_m        <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (MDValidE && !AbortE) begin
            if (w_is_mul || w_is_divop) begin
              r_state    <= RUN;
              r_cnt      <= CW'(ITERS);
              r_is_div   <= w_is_divop;
              r_m        <= w_is_divop ? w_b_abs : w_a_abs;
              r_acc_lo   <= w_is_divop ? w_a_abs : w_b_abs;
              r_acc_hi   <= '0;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_div_zero <= w_is_divop && (SrcBE == '0);
            end else if (MDOpE == MD_MTHI) begin
              r_hi <= SrcAE;
            end else if (MDOpE == MD_MTLO) begin
              r_lo <= SrcAE;
            end
          end
        end
        RUN: begin
          if (AbortE) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc_hi <= w_hi_chain[R];
            r_acc_lo <= w_lo_chain[R];
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!AbortE) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BusyE   = (r_state != IDLE);
  assign StallMD = BusyE & MDValidE;
  assign MDOutE  = (MDOpE == MD_MFHI) ? r_hi : r_lo;
  assign DoneE   = r_done;

endmodule
